// File: rtl/bp_cfg_link_pkg.sv
// Shared definitions for the tile configuration link responder.
// Contents:
//   bp_cfg_op_e     - command opcodes carried in the first flit of a packet
//   cfg_ack_*       - single-flit response codes
//   bp_cfg_state_e  - responder FSM states
//   max_int / safe_clog2 - elaboration-time sizing helpers
package bp_cfg_link_pkg;

  typedef enum logic [7:0] {
    e_cfg_wr = 8'h01,
    e_cfg_rd = 8'h02
  } bp_cfg_op_e;

  localparam logic [7:0] cfg_ack_ok      = 8'h01;
  localparam logic [7:0] cfg_ack_badaddr = 8'hFF;
  localparam logic [7:0] cfg_ack_badop   = 8'hEE;

  typedef enum logic [1:0] {
    e_idle,
    e_addr,
    e_data,
    e_resp
  } bp_cfg_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_cfg_link_shifter.sv
// Flit-granular shift register used both as the command deserializer and the
// response serializer. Flits enter at the MS end and the register shifts
// toward the LS end, so a word streamed LS flit first ends up in natural bit
// order, and the LS flit of a loaded word is the first one presented.
// Ports:
//   clk_i, reset_i  - clock, synchronous active-high clear
//   load_i          - parallel load of load_data_i (wins over shift_i)
//   load_data_i     - word to load
//   shift_i         - shift one flit in at the top / out at the bottom
//   shift_data_i    - flit entering at the MS end
//   data_o          - current register contents (LS flit = data_o[link-1:0])
//   shift_next_o    - value the register takes if shift_i is asserted now
module bp_cfg_link_shifter
  import bp_cfg_link_pkg::*;
#(
  parameter int width_p      = 64,
  parameter int link_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    load_i,
  input  logic [width_p-1:0]      load_data_i,
  input  logic                    shift_i,
  input  logic [link_width_p-1:0] shift_data_i,
  output logic [width_p-1:0]      data_o,
  output logic [width_p-1:0]      shift_next_o
);

  logic [width_p-1:0] data_q;

  generate
    if (width_p == link_width_p) begin : g_single
      assign shift_next_o = shift_data_i;
    end else begin : g_multi
      assign shift_next_o = {shift_data_i, data_q[width_p-1:link_width_p]};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (shift_i) begin
      data_q <= shift_next_o;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bp_cfg_link_responder.sv
// Target end of the byte-serial configuration link. Deserializes WRITE/READ
// command packets, updates or reads a bank of configuration registers and
// streams back a response. Exactly one packet is in flight at a time.
// Ports:
//   clk_i, reset_i           - clock, synchronous active-high reset
//   link_data_i/_v_i/_ready_o - command flit stream (valid/ready)
//   resp_data_o/_v_o/_yumi_i  - response flit stream (valid/yumi)
//   cfg_regs_o               - flattened register bank, reg i at [i*W +: W]
//   freeze_o                 - reg0 bit 0
module bp_cfg_link_responder
  import bp_cfg_link_pkg::*;
#(
  parameter int data_width_p = 64,
  parameter int addr_width_p = 16,
  parameter int num_regs_p   = 8,
  parameter int link_width_p = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [link_width_p-1:0]            link_data_i,
  input  logic                               link_v_i,
  output logic                               link_ready_o,
  output logic [link_width_p-1:0]            resp_data_o,
  output logic                               resp_v_o,
  input  logic                               resp_yumi_i,
  output logic [num_regs_p*data_width_p-1:0] cfg_regs_o,
  output logic                               freeze_o
);

  localparam int addr_flits_lp = addr_width_p / link_width_p;
  localparam int data_flits_lp = data_width_p / link_width_p;
  localparam int cmd_width_lp  = max_int(addr_width_p, data_width_p);
  localparam int cnt_width_lp  = safe_clog2(max_int(addr_flits_lp, data_flits_lp));
  localparam int idx_width_lp  = safe_clog2(num_regs_p);

  localparam logic [cnt_width_lp-1:0] addr_last_lp = cnt_width_lp'(addr_flits_lp - 1);
  localparam logic [cnt_width_lp-1:0] data_last_lp = cnt_width_lp'(data_flits_lp - 1);
  localparam logic [addr_width_p-1:0] num_regs_lp  = addr_width_p'(num_regs_p);

  bp_cfg_state_e             state_q, state_n;
  logic [cnt_width_lp-1:0]   cnt_q, cnt_n;
  logic                      is_rd_q, is_rd_n;
  logic [addr_width_p-1:0]   addr_q;
  logic                      addr_ld;
  logic [data_width_p-1:0]   regs_q [num_regs_p];
  logic                      wr_en;

  logic                      accept;
  logic [7:0]                op_flit;

  logic                      cmd_shift;
  logic [cmd_width_lp-1:0]   cmd_q, cmd_next;
  logic [addr_width_p-1:0]   addr_full;
  logic [data_width_p-1:0]   wr_data;
  logic [data_width_p-1:0]   rd_val;

  logic                      resp_load, resp_shift;
  logic [data_width_p-1:0]   resp_load_data;
  logic [data_width_p-1:0]   resp_q, resp_next;
  logic                      unused_bits;

  function automatic logic in_range(input logic [addr_width_p-1:0] a);
    return (a < num_regs_lp);
  endfunction

  function automatic logic [data_width_p-1:0] code_word(input logic [7:0] c);
    return data_width_p'(c);
  endfunction

  // Command deserializer: address and data both stream into the MS end; the
  // values are taken from shift_next so they are usable on the accepting edge.
  bp_cfg_link_shifter #(
    .width_p      (cmd_width_lp),
    .link_width_p (link_width_p)
  ) cmd_shifter (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_i       (1'b0),
    .load_data_i  ('0),
    .shift_i      (cmd_shift),
    .shift_data_i (link_data_i),
    .data_o       (cmd_q),
    .shift_next_o (cmd_next)
  );

  assign addr_full = cmd_next[cmd_width_lp-1 -: addr_width_p];
  assign wr_data   = cmd_next[cmd_width_lp-1 -: data_width_p];

  // Response serializer: loaded on entry to e_resp, shifted on each yumi.
  bp_cfg_link_shifter #(
    .width_p      (data_width_p),
    .link_width_p (link_width_p)
  ) resp_shifter (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_i       (resp_load),
    .load_data_i  (resp_load_data),
    .shift_i      (resp_shift),
    .shift_data_i ('0),
    .data_o       (resp_q),
    .shift_next_o (resp_next)
  );

  assign unused_bits = ^{cmd_q, cmd_next, resp_q, resp_next};

  assign link_ready_o = (state_q != e_resp);
  assign resp_v_o     = (state_q == e_resp);
  assign resp_data_o  = resp_q[link_width_p-1:0];
  assign accept       = link_v_i & link_ready_o;
  assign op_flit      = 8'(link_data_i);

  always_comb begin
    rd_val = '0;
    if (in_range(addr_full)) begin
      rd_val = regs_q[addr_full[idx_width_lp-1:0]];
    end
  end

  // Stage: next-state / control decode
  always_comb begin
    state_n        = state_q;
    cnt_n          = cnt_q;
    is_rd_n        = is_rd_q;
    addr_ld        = 1'b0;
    wr_en          = 1'b0;
    cmd_shift      = 1'b0;
    resp_load      = 1'b0;
    resp_load_data = '0;
    resp_shift     = 1'b0;

    unique case (state_q)
      e_idle: begin
        if (accept) begin
          cnt_n = '0;
          if (op_flit == e_cfg_wr) begin
            is_rd_n = 1'b0;
            state_n = e_addr;
          end else if (op_flit == e_cfg_rd) begin
            is_rd_n = 1'b1;
            state_n = e_addr;
          end else begin
            // Unknown opcode: answer at once; nothing else of this packet is read.
            is_rd_n        = 1'b0;
            resp_load      = 1'b1;
            resp_load_data = code_word(cfg_ack_badop);
            state_n        = e_resp;
          end
        end
      end

      e_addr: begin
        if (accept) begin
          cmd_shift = 1'b1;
          if (cnt_q == addr_last_lp) begin
            cnt_n   = '0;
            addr_ld = 1'b1;
            if (is_rd_q) begin
              resp_load      = 1'b1;
              resp_load_data = rd_val;
              state_n        = e_resp;
            end else begin
              state_n = e_data;
            end
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end

      e_data: begin
        if (accept) begin
          cmd_shift = 1'b1;
          if (cnt_q == data_last_lp) begin
            cnt_n          = '0;
            wr_en          = in_range(addr_q);
            resp_load      = 1'b1;
            resp_load_data = in_range(addr_q) ? code_word(cfg_ack_ok)
                                              : code_word(cfg_ack_badaddr);
            state_n        = e_resp;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end

      e_resp: begin
        if (resp_yumi_i) begin
          if (!is_rd_q || (cnt_q == data_last_lp)) begin
            cnt_n   = '0;
            state_n = e_idle;
          end else begin
            cnt_n      = cnt_q + 1'b1;
            resp_shift = 1'b1;
          end
        end
      end

      default: state_n = e_idle;
    endcase
  end

  // Stage: control registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      cnt_q   <= '0;
      is_rd_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      is_rd_q <= is_rd_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (addr_ld) begin
      addr_q <= addr_full;
    end
  end

  // Stage: register bank (reg0 resets to 1 so the tile comes up frozen)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_regs_p; i++) begin
        regs_q[i] <= (i == 0) ? data_width_p'(1) : '0;
      end
    end else if (wr_en) begin
      regs_q[addr_q[idx_width_lp-1:0]] <= wr_data;
    end
  end

  generate
    for (genvar g = 0; g < num_regs_p; g++) begin : g_flat
      assign cfg_regs_o[g*data_width_p +: data_width_p] = regs_q[g];
    end
  endgenerate

  assign freeze_o = regs_q[0][0];

endmodule

// File: tb/tb_bp_cfg_link_responder.sv
// Self-checking bench for bp_cfg_link_responder: directed packets followed by
// randomized traffic with random flit gaps and response back-pressure, checked
// against a register-array reference model.
module tb_bp_cfg_link_responder;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int NR = 8;
  localparam int LW = 8;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [LW-1:0]    link_data_i;
  logic             link_v_i;
  logic             link_ready_o;
  logic [LW-1:0]    resp_data_o;
  logic             resp_v_o;
  logic             resp_yumi_i;
  logic [NR*DW-1:0] cfg_regs_o;
  logic             freeze_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ref_regs [NR];

  bp_cfg_link_responder #(
    .data_width_p (DW),
    .addr_width_p (AW),
    .num_regs_p   (NR),
    .link_width_p (LW)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .link_data_i  (link_data_i),
    .link_v_i     (link_v_i),
    .link_ready_o (link_ready_o),
    .resp_data_o  (resp_data_o),
    .resp_v_o     (resp_v_o),
    .resp_yumi_i  (resp_yumi_i),
    .cfg_regs_o   (cfg_regs_o),
    .freeze_o     (freeze_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) ref_regs[i] = (i == 0) ? 64'd1 : 64'd0;
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < NR; i++) check_val(tag, cfg_regs_o[i*DW +: DW], ref_regs[i]);
    check_val({tag, "_freeze"}, freeze_o, ref_regs[0][0]);
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    reset_i     = 1'b1;
    link_v_i    = 1'b0;
    resp_yumi_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    model_reset();
  endtask

  // Present one command flit and hold it until accepted.
  task automatic send_flit(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_i);
    @(negedge clk_i);
    link_data_i = b;
    link_v_i    = 1'b1;
    while (!link_ready_o && guard < 200) begin
      @(negedge clk_i);
      guard++;
    end
    check_val("link_ready", link_ready_o, 1);
    @(posedge clk_i);
    #1 link_v_i = 1'b0;
  endtask

  // Receive one response flit; 'first' demands it be valid with no wait.
  task automatic recv_flit(input logic [7:0] exp, input bit stall, input bit first, input string tag);
    int guard = 0;
    @(negedge clk_i);
    if (!first) begin
      while (!resp_v_o && guard < 200) begin
        @(negedge clk_i);
        guard++;
      end
    end
    check_val({tag, "_valid"}, resp_v_o, 1);
    check_val({tag, "_ready_low"}, link_ready_o, 0);
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        check_val({tag, "_hold"}, resp_data_o, exp);
        @(negedge clk_i);
        check_val({tag, "_hold_v"}, resp_v_o, 1);
      end
    end
    check_val(tag, resp_data_o, exp);
    resp_yumi_i = 1'b1;
    @(posedge clk_i);
    #1 resp_yumi_i = 1'b0;
  endtask

  task automatic check_done(input string tag);
    @(negedge clk_i);
    check_val({tag, "_resp_v_off"}, resp_v_o, 0);
    check_val({tag, "_ready_on"}, link_ready_o, 1);
  endtask

  task automatic pkt_write(input logic [15:0] addr, input logic [63:0] data, input bit gaps, input bit stall);
    logic [7:0] code;
    send_flit(8'h01, gaps);
    for (int i = 0; i < 2; i++) send_flit(addr[8*i +: 8], gaps);
    for (int i = 0; i < 8; i++) send_flit(data[8*i +: 8], gaps);
    if (addr < NR) begin
      ref_regs[addr] = data;
      code = 8'h01;
    end else begin
      code = 8'hFF;
    end
    // Commit is already visible in the cycle after the last data flit.
    check_bank("wr_bank");
    recv_flit(code, stall, 1'b1, "wr_ack");
    check_done("wr");
  endtask

  task automatic pkt_read(input logic [15:0] addr, input bit gaps, input bit stall);
    logic [63:0] exp;
    send_flit(8'h02, gaps);
    for (int i = 0; i < 2; i++) send_flit(addr[8*i +: 8], gaps);
    exp = (addr < NR) ? ref_regs[addr] : 64'd0;
    for (int i = 0; i < 8; i++) recv_flit(exp[8*i +: 8], stall, (i == 0), "rd_data");
    check_done("rd");
  endtask

  task automatic pkt_badop(input logic [7:0] op, input bit stall);
    send_flit(op, 1'b0);
    recv_flit(8'hEE, stall, 1'b1, "badop");
    check_done("badop");
  endtask

  initial begin
    logic [63:0] d;
    logic [15:0] a;
    logic [7:0]  op;
    int          r;

    reset_i     = 1'b1;
    link_v_i    = 1'b0;
    link_data_i = '0;
    resp_yumi_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    @(negedge clk_i);
    check_bank("rst_bank");
    check_val("rst_freeze", freeze_o, 1);
    check_val("rst_ready", link_ready_o, 1);
    check_val("rst_resp_v", resp_v_o, 0);
    check_val("rst_resp_data", resp_data_o, 0);

    // Unfreeze via reg0.
    pkt_write(16'h0000, 64'd0, 1'b0, 1'b0);
    check_val("unfrozen", freeze_o, 0);

    pkt_write(16'd3, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    pkt_read(16'd3, 1'b0, 1'b0);

    // Out-of-range accesses, including the first address past the bank.
    pkt_write(16'h0008, 64'hDEAD_BEEF_0000_1111, 1'b0, 1'b0);
    pkt_read(16'h0100, 1'b0, 1'b0);
    pkt_read(16'h0008, 1'b0, 1'b1);

    // Illegal opcode, then the following flit starts a fresh packet.
    apply_reset();
    pkt_badop(8'h7A, 1'b0);
    pkt_read(16'h0000, 1'b0, 1'b0);

    // Reset part-way through a write to reg 2.
    send_flit(8'h01, 1'b0);
    send_flit(8'h02, 1'b0);
    send_flit(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) send_flit(8'hA0 + 8'(i), 1'b0);
    apply_reset();
    @(negedge clk_i);
    check_bank("abort_bank");
    check_val("abort_resp_v", resp_v_o, 0);
    check_val("abort_ready", link_ready_o, 1);
    pkt_write(16'd2, 64'hFEED_FACE_CAFE_0002, 1'b0, 1'b0);
    pkt_read(16'd2, 1'b1, 1'b1);

    // Randomized traffic with gaps and back-pressure.
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
      d = {$urandom, $urandom};
      if (r < 4) begin
        pkt_write(a, d, 1'($urandom), 1'($urandom));
      end else if (r < 9) begin
        pkt_read(a, 1'($urandom), 1'($urandom));
      end else begin
        op = 8'($urandom);
        if (op == 8'h01 || op == 8'h02) op = 8'hC3;
        pkt_badop(op, 1'($urandom));
      end
    end

    @(negedge clk_i);
    check_bank("final_bank");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
